// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
//   state_t : sequencer FSM states
//   fault_t : cause reported when the sequencer enters ST_FAULT
package hilo_pkg;

   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 40;
   localparam int unsigned CNT_W                  = 8;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_DIV  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_COMMIT = 3'd3,
      ST_FAULT  = 3'd4
   } state_t;

   typedef enum logic {
      FC_DIV_ZERO = 1'b0,
      FC_TIMEOUT  = 1'b1
   } fault_t;

endpackage

// File: rtl/hilo_timeout_counter.sv
// Loadable down-counter that watches for a stuck arithmetic unit.
//   clk, reset  : clock, async active-low reset
//   load        : load load_val (wins over dec)
//   load_val    : reload value
//   dec         : decrement by one, saturating at zero
//   expired_c   : count is zero (decoded from the count register)
module hilo_timeout_counter
   import hilo_pkg::*;
#(
   parameter int unsigned W = CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         expired_c
);

   logic [W-1:0] cnt;

   // Count register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign expired_c = (cnt == '0);

endmodule

// File: rtl/hilo_sequencer.sv
// Sequences the shared multiplier/divider and owns the HI/LO registers.
//   Control side : req_valid/req_op/req_a/req_b/req_ready, abort,
//                  done/div_zero/timeout pulses
//   Unit side    : mult_start/div_start, unit_a/unit_b operands,
//                  mult_ready/mult_hi/mult_lo, div_ready/div_hi/div_lo
//   Direct write : hi_wr/lo_wr/wr_data (MTHI/MTLO), honoured only when idle
//   State        : hi_out/lo_out
module hilo_sequencer
   import hilo_pkg::*;
#(
   parameter int unsigned WIDTH          = 32,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic             req_op,
   input  logic [WIDTH-1:0] req_a,
   input  logic [WIDTH-1:0] req_b,
   output logic             req_ready,
   input  logic             abort,
   output logic             mult_start,
   output logic             div_start,
   output logic [WIDTH-1:0] unit_a,
   output logic [WIDTH-1:0] unit_b,
   input  logic             mult_ready,
   input  logic [WIDTH-1:0] mult_hi,
   input  logic [WIDTH-1:0] mult_lo,
   input  logic             div_ready,
   input  logic [WIDTH-1:0] div_hi,
   input  logic [WIDTH-1:0] div_lo,
   input  logic             hi_wr,
   input  logic             lo_wr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             done,
   output logic             div_zero,
   output logic             timeout
);

   // Counter reload: LAUNCH loads N-1 so WAIT lasts at most N cycles
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t           state;
   logic             op_reg;
   logic             sel_ready_c;
   logic [WIDTH-1:0] sel_hi_c;
   logic [WIDTH-1:0] sel_lo_c;
   logic             cnt_load_c;
   logic             cnt_dec_c;
   logic             cnt_expired_c;
   logic             enter_fault_c;
   fault_t           fault_cause_c;

   // Only the launched unit's handshake is ever looked at
   assign sel_ready_c = (op_reg == OP_DIV) ? div_ready : mult_ready;
   assign sel_hi_c    = (op_reg == OP_DIV) ? div_hi    : mult_hi;
   assign sel_lo_c    = (op_reg == OP_DIV) ? div_lo    : mult_lo;

   // Held low while reset is asserted, idle-decoded otherwise
   assign req_ready = reset && (state == ST_IDLE);

   assign cnt_load_c = (state == ST_LAUNCH);
   assign cnt_dec_c  = (state == ST_WAIT) && !sel_ready_c && !cnt_expired_c;

   hilo_timeout_counter #(
      .W (CNT_W)
   ) u_timeout_counter (
      .clk       (clk),
      .reset     (reset),
      .load      (cnt_load_c),
      .load_val  (CNT_LOAD),
      .dec       (cnt_dec_c),
      .expired_c (cnt_expired_c)
   );

   // Fault entry decode; its cause selects which pulse fires in ST_FAULT
   always_comb begin
      enter_fault_c = 1'b0;
      fault_cause_c = FC_TIMEOUT;
      if ((state == ST_IDLE) && req_valid && (req_op == OP_DIV) && (req_b == '0)) begin
         enter_fault_c = 1'b1;
         fault_cause_c = FC_DIV_ZERO;
      end else if ((state == ST_WAIT) && !abort && !sel_ready_c && cnt_expired_c) begin
         enter_fault_c = 1'b1;
         fault_cause_c = FC_TIMEOUT;
      end
   end

   // Sequencer FSM with registered outputs and HI/LO state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         op_reg     <= OP_MULT;
         unit_a     <= '0;
         unit_b     <= '0;
         hi_out     <= '0;
         lo_out     <= '0;
         mult_start <= 1'b0;
         div_start  <= 1'b0;
         done       <= 1'b0;
         div_zero   <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         mult_start <= 1'b0;
         div_start  <= 1'b0;
         done       <= 1'b0;
         div_zero   <= enter_fault_c && (fault_cause_c == FC_DIV_ZERO);
         timeout    <= enter_fault_c && (fault_cause_c == FC_TIMEOUT);

         case (state)
            ST_IDLE: begin
               // Direct writes land even on an accept edge; the commit overwrites later
               if (hi_wr) hi_out <= wr_data;
               if (lo_wr) lo_out <= wr_data;
               if (req_valid) begin
                  op_reg <= req_op;
                  unit_a <= req_a;
                  unit_b <= req_b;
                  if (enter_fault_c) begin
                     state <= ST_FAULT;
                  end else begin
                     state      <= ST_LAUNCH;
                     mult_start <= (req_op == OP_MULT);
                     div_start  <= (req_op == OP_DIV);
                  end
               end
            end

            ST_LAUNCH: begin
               state <= abort ? ST_IDLE : ST_WAIT;
            end

            ST_WAIT: begin
               if (abort) begin
                  state <= ST_IDLE;
               end else if (sel_ready_c) begin
                  hi_out <= sel_hi_c;
                  lo_out <= sel_lo_c;
                  done   <= 1'b1;
                  state  <= ST_COMMIT;
               end else if (enter_fault_c) begin
                  state <= ST_FAULT;
               end
            end

            // HI/LO already written on entry, so abort cannot cancel it
            ST_COMMIT: state <= ST_IDLE;

            ST_FAULT:  state <= ST_IDLE;

            default:   state <= ST_IDLE;
         endcase
      end
   end

endmodule
